r5p_mdu_seq: RTL and testbench
==============================

# r5p_mdu_seq

Multi-cycle sequencer for the RISC-V M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It adds no adder of its own. It borrows the core's shared ALU, issuing one `alu_t` control word plus operands per cycle for operand negation, shift-add multiply, restoring divide and result negation. It sits beside the execute stage and stalls the pipeline through `alu_own` while it holds the ALU.

## Interface
- `XLEN`, 32: data width; loop count equals `XLEN`.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_vld` in 1: request valid.
- `req_rdy` out 1: request ready; high only in IDLE.
- `req_op` in 3: `mdu_op_t`, funct3 encoding (MUL=0 … REMU=7).
- `req_rs1` in XLEN: multiplicand/dividend.
- `req_rs2` in XLEN: multiplier/divisor.
- `kill` in 1: pipeline flush; aborts any operation in flight.
- `rsp_vld` out 1: result valid.
- `rsp_rdy` in 1: result accepted.
- `rsp_rd` out XLEN: result.
- `alu_own` out 1: sequencer drives the shared ALU; the pipeline muxes the ALU inputs and stalls.
- `alu_ctl` out `alu_t`: ALU control. `ai`=AI_R1_R2 and `rt`=R_X always; `ao` is AO_ADD or AO_SUB.
- `alu_rs1`, `alu_rs2` out XLEN: ALU operands.
- `alu_rd` in XLEN: ALU result, same cycle (combinational).

## Operation
- States: IDLE, NEG1, NEG2, LOOP, FIX1, FIX2, DONE.
- IDLE, on `req_vld`: latch op and operands, then classify.
  - DIV/REM with rs2==0: go to DONE. Quotient all-ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1=0x8000_0000, rs2=all-ones): go to DONE. Quotient = rs1; remainder = 0.
  - Otherwise go to NEG1.
- Sign flags: `s1` = rs1[XLEN-1] for MUL/MULH/MULHSU/DIV/REM. `s2` = rs2[XLEN-1] for MUL/MULH/DIV/REM. Each flag is 0 otherwise.
- NEG1: ALU 0 − rs1; store the magnitude (result if `s1`, else rs1).
- NEG2: ALU 0 − rs2; store the magnitude (result if `s2`, else rs2).
- Multiply step, run `XLEN` times: hi init 0, lo = |rs1|, m = |rs2|.
  - ALU ADD with operands hi and (lo[0] ? m : 0).
  - carry = `alu_rd` <u `alu_rs1`.
  - hi ← {carry, alu_rd[XLEN-1:1]}; lo ← {alu_rd[0], lo[XLEN-1:1]}.
- Divide step, run `XLEN` times: r init 0, q = |rs1|, d = |rs2|.
  - sh = {r[XLEN-2:0], q[XLEN-1]}.
  - ALU SUB with operands sh and d.
  - acc = r[XLEN-1] | (sh ≥u d).
  - r ← acc ? alu_rd : sh; q ← {q[XLEN-2:0], acc}.
- Negate flags: product/quotient negate = s1^s2; remainder negate = s1.
- FIX1: ALU 0 − word. The word is lo (MUL*), q (DIV*) or r (REM*). Store the result if that word's negate flag is set; record `lo_zero` = (lo==0).
- FIX2, MULH* with negate set: ALU 0 − hi; hi ← lo_zero ? alu_rd : ~hi.
- Result select: MUL=lo, MULH*=hi, DIV*=q, REM*=r.
- DONE: `rsp_vld`=1 and `rsp_rd` hold stable until `rsp_rdy`, then return to IDLE.
- `kill` outside IDLE: return to IDLE next cycle; no response. `kill` in IDLE blocks acceptance that cycle.
- Width rules: all ALU operations are full XLEN. Carry and borrow come from local unsigned comparators, never from ALU overflow.

## Timing
- Accept = `req_vld` & `req_rdy` at clock edge 0.
- Normal latency is fixed, independent of op and operand values:
  - NEG1 in cycle 1, NEG2 in cycle 2.
  - LOOP in cycles 3 … XLEN+2.
  - FIX1 in XLEN+3, FIX2 in XLEN+4.
  - `rsp_vld` in cycle XLEN+5 (37 for XLEN=32).
- Special cases: `rsp_vld` in cycle 1.
- `alu_own`=1 in NEG1 … FIX2 only; 0 in IDLE and DONE.
- When `alu_own`=0, `alu_ctl` = AO_ADD/AI_R1_R2/R_X and operands are 0.
- Response handshake completes on an edge with `rsp_vld` & `rsp_rdy`. `req_rdy` rises the following cycle; back-to-back is impossible.
- Reset values: state IDLE, `req_rdy`=1, `rsp_vld`=0, `rsp_rd`=0, `alu_own`=0, all datapath registers 0. Reset asserted mid-operation discards the operation immediately (asynchronous).

## Structure
- `riscv_isa_pkg` gains `mdu_op_t` (funct3 encodings MUL … REMU).
- State enum stays local to the module.
- No sub-module: the ALU is shared and instantiated outside. Comparators and the loop counter (`$clog2(XLEN)` bits, wraps to 0 at LOOP exit) are inline.

## Test plan
- MUL and MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001 / 0xFFFFFFFE. `rsp_vld` in cycle 37; `alu_own` high for cycles 1–36.
- MUL/MULH, −7 × 3 → 0xFFFFFFEB / 0xFFFFFFFF. MULHSU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULH, 0 × −5 → 0.
- DIV/REM, −7 / 2 → 0xFFFFFFFD / 0xFFFFFFFF. DIVU/REMU, 7 / 2 → 3 / 1. REM, 7 / −2 → 1.
- Special cases, each with `rsp_vld` in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000; REM → 0.
- Backpressure: `rsp_rdy` low 10 cycles in DONE → `rsp_rd` stable and `req_rdy`=0. Release → IDLE; next request accepted.
- Abort:
  - `kill` in LOOP cycle 10 → IDLE next cycle, `alu_own`=0, no `rsp_vld`.
  - `rst` low in LOOP → all outputs at reset values asynchronously. A new request after reset completes correctly.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// Shared ISA types: M-extension op encodings and the shared ALU control word.
package riscv_isa_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  // ALU input select
  typedef enum logic [1:0] {
    AI_R1_R2 = 2'd0,
    AI_R1_IM = 2'd1,
    AI_PC_IM = 2'd2,
    AI_PC_R2 = 2'd3
  } ai_t;

  // ALU operation
  typedef enum logic [3:0] {
    AO_ADD  = 4'd0,
    AO_SUB  = 4'd1,
    AO_SLL  = 4'd2,
    AO_SLT  = 4'd3,
    AO_SLTU = 4'd4,
    AO_XOR  = 4'd5,
    AO_SRL  = 4'd6,
    AO_SRA  = 4'd7,
    AO_OR   = 4'd8,
    AO_AND  = 4'd9
  } ao_t;

  // ALU result type (X = full width)
  typedef enum logic [1:0] {
    R_X = 2'd0,
    R_W = 2'd1
  } rt_t;

  typedef struct packed {
    ai_t ai;
    ao_t ao;
    rt_t rt;
  } alu_t;

  localparam alu_t ALU_IDLE = '{ai: AI_R1_R2, ao: AO_ADD, rt: R_X};

  // rs1 is treated as signed
  function automatic logic mdu_s1_signed(input mdu_op_t op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic mdu_s2_signed(input mdu_op_t op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

  // result is the high product word
  function automatic logic mdu_is_mulh(input mdu_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

  // result is the remainder
  function automatic logic mdu_is_rem(input mdu_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/r5p_mdu_seq.sv
// Multi-cycle MUL/DIV sequencer that borrows the core's shared ALU.
// Register roles: lo = low product / quotient, hi = high product / remainder,
// md = multiplier / divisor magnitude.
//
// state | meaning
// IDLE  | waiting for a request, req_rdy high
// NEG1  | magnitude of rs1 via ALU 0 - rs1
// NEG2  | magnitude of rs2 via ALU 0 - rs2
// LOOP  | XLEN shift-add or restoring-divide steps
// FIX1  | negate low/quotient/remainder word if its sign requires it
// FIX2  | finish 64-bit negation of the high product word
// DONE  | result held on rsp_rd until rsp_rdy
module r5p_mdu_seq
  import riscv_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            kill,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_rd,
  output logic            alu_own,
  output alu_t            alu_ctl,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_rd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, NEG1, NEG2, LOOP, FIX1, FIX2, DONE} state_t;

  state_t          state, state_nxt;
  mdu_op_t         op;
  logic            s1, s2;
  logic            lo_zero;
  logic [XLEN-1:0] lo, hi, md;
  logic [CW-1:0]   cnt;

  mdu_op_t         op_in;
  logic            accept;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] sh;
  logic            acc, carry;
  logic            fix_neg;
  logic [XLEN-1:0] fix_word;

  assign op_in    = mdu_op_t'(req_op);
  assign accept   = req_vld && !kill;
  assign div_zero = op_in[2] && (req_rs2 == '0);
  assign div_ovf  = ((op_in == DIV) || (op_in == REM)) && (req_rs1 == XMIN) && (req_rs2 == '1);

  // Restoring divide: the 33rd bit of the shifted remainder is hi[MSB],
  // which forces the subtract because the true value then exceeds any divisor.
  assign sh    = {hi[XLEN-2:0], lo[XLEN-1]};
  assign acc   = hi[XLEN-1] | (sh >= md);
  // Shift-add multiply: carry out of hi + addend recovered by compare.
  assign carry = alu_rd < hi;

  assign fix_word = mdu_is_rem(op) ? hi : lo;
  assign fix_neg  = mdu_is_rem(op) ? s1 : (s1 ^ s2);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, handshake and ALU drive
  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    rsp_rd    = '0;
    alu_own   = 1'b0;
    alu_ctl   = ALU_IDLE;
    alu_rs1   = '0;
    alu_rs2   = '0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (accept) state_nxt = (div_zero || div_ovf) ? DONE : NEG1;
      end
      NEG1: begin
        alu_own    = 1'b1;
        alu_ctl.ao = AO_SUB;
        alu_rs2    = lo;
        state_nxt  = NEG2;
      end
      NEG2: begin
        alu_own    = 1'b1;
        alu_ctl.ao = AO_SUB;
        alu_rs2    = md;
        state_nxt  = LOOP;
      end
      LOOP: begin
        alu_own = 1'b1;
        if (op[2]) begin
          alu_ctl.ao = AO_SUB;
          alu_rs1    = sh;
          alu_rs2    = md;
        end else begin
          alu_rs1 = hi;
          alu_rs2 = lo[0] ? md : '0;
        end
        if (cnt == CNT_LAST) state_nxt = FIX1;
      end
      FIX1: begin
        alu_own    = 1'b1;
        alu_ctl.ao = AO_SUB;
        alu_rs2    = fix_word;
        state_nxt  = FIX2;
      end
      FIX2: begin
        alu_own    = 1'b1;
        alu_ctl.ao = AO_SUB;
        alu_rs2    = hi;
        state_nxt  = DONE;
      end
      DONE: begin
        rsp_vld = 1'b1;
        rsp_rd  = ((op == MUL) || (op == DIV) || (op == DIVU)) ? lo : hi;
        if (rsp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill && (state != IDLE)) state_nxt = IDLE;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op      <= MUL;
      s1      <= 1'b0;
      s2      <= 1'b0;
      lo_zero <= 1'b0;
      lo      <= '0;
      hi      <= '0;
      md      <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op      <= op_in;
          s1      <= mdu_s1_signed(op_in) & req_rs1[XLEN-1];
          s2      <= mdu_s2_signed(op_in) & req_rs2[XLEN-1];
          lo_zero <= 1'b0;
          cnt     <= '0;
          md      <= req_rs2;
          // divide-by-zero results land directly in the q/r registers;
          // overflow already has q = rs1, r = 0 in place
          lo      <= div_zero ? '1 : req_rs1;
          hi      <= div_zero ? req_rs1 : '0;
        end
        NEG1: if (s1) lo <= alu_rd;
        NEG2: if (s2) md <= alu_rd;
        LOOP: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            hi <= acc ? alu_rd : sh;
            lo <= {lo[XLEN-2:0], acc};
          end else begin
            hi <= {carry, alu_rd[XLEN-1:1]};
            lo <= {alu_rd[0], lo[XLEN-1:1]};
          end
        end
        FIX1: begin
          lo_zero <= (lo == '0);
          if (fix_neg) begin
            if (mdu_is_rem(op)) hi <= alu_rd;
            else                lo <= alu_rd;
          end
        end
        FIX2: if (mdu_is_mulh(op) && (s1 ^ s2)) hi <= lo_zero ? alu_rd : ~hi;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r5p_mdu_seq.sv
// Self-checking bench for r5p_mdu_seq with a behavioural shared-ALU model.
module tb_r5p_mdu_seq;
  import riscv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        kill = 1'b0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_rd;
  logic        alu_own;
  alu_t        alu_ctl;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;

  int n_cmp = 0;
  int n_err = 0;

  r5p_mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rd(rsp_rd),
    .alu_own(alu_own), .alu_ctl(alu_ctl),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd)
  );

  // shared ALU, combinational
  assign alu_rd = (alu_ctl.ao == AO_SUB) ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // reference: RISC-V M semantics from plain wide arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_vld = 1'b1;
    req_op  = op;
    req_rs1 = a;
    req_rs2 = b;
    @(posedge clk);
    #1 req_vld = 1'b0;
  endtask

  // cycle 1 is the cycle after the accept edge; alu_own expected in cycles < lat
  task automatic wait_rsp(input int limit, input int lat, output int cyc, output int own_bad);
    cyc = 0;
    own_bad = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (alu_own !== (cyc < lat)) own_bad++;
      if (rsp_vld === 1'b1) break;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int  cyc, bad, lat;
    bit  special;
    special = op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hffffffff));
    lat = special ? 1 : 37;
    issue(op, a, b);
    wait_rsp(60, lat, cyc, bad);
    chk({name, " latency"}, 32'(cyc), 32'(lat));
    chk({name, " rd"}, rsp_rd, exp);
    chk({name, " alu_own"}, 32'(bad), 32'd0);
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
    chk({name, " idle after rsp"}, 32'({req_rdy, rsp_vld}), 32'b10);
  endtask

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk_reset_outputs(input string name);
    chk({name, " flags"}, 32'({req_rdy, rsp_vld, alu_own}), 32'b100);
    chk({name, " rsp_rd"}, rsp_rd, 32'd0);
    chk({name, " alu_rs1"}, alu_rs1, 32'd0);
    chk({name, " alu_rs2"}, alu_rs2, 32'd0);
    chk({name, " alu_ctl"}, {24'd0, alu_ctl}, {24'd0, ALU_IDLE});
  endtask

  initial begin
    int cyc, bad, hits;
    logic [2:0]  rop;
    logic [31:0] ra, rb, held;

    vecs.push_back('{MUL,    32'hffffffff, 32'hffffffff, 32'h00000001});
    vecs.push_back('{MULHU,  32'hffffffff, 32'hffffffff, 32'hfffffffe});
    vecs.push_back('{MUL,    32'hfffffff9, 32'h00000003, 32'hffffffeb});
    vecs.push_back('{MULH,   32'hfffffff9, 32'h00000003, 32'hffffffff});
    vecs.push_back('{MULHSU, 32'hffffffff, 32'hffffffff, 32'hffffffff});
    vecs.push_back('{MULH,   32'h00000000, 32'hfffffffb, 32'h00000000});
    vecs.push_back('{MULH,   32'h80000000, 32'h00000002, 32'hffffffff});
    vecs.push_back('{MULH,   32'h80000000, 32'h80000000, 32'h40000000});
    vecs.push_back('{MULHSU, 32'h80000000, 32'hffffffff, 32'h80000000});
    vecs.push_back('{DIV,    32'hfffffff9, 32'h00000002, 32'hfffffffd});
    vecs.push_back('{REM,    32'hfffffff9, 32'h00000002, 32'hffffffff});
    vecs.push_back('{DIVU,   32'h00000007, 32'h00000002, 32'h00000003});
    vecs.push_back('{REMU,   32'h00000007, 32'h00000002, 32'h00000001});
    vecs.push_back('{REM,    32'h00000007, 32'hfffffffe, 32'h00000001});
    vecs.push_back('{DIV,    32'h00000005, 32'h00000000, 32'hffffffff});
    vecs.push_back('{REM,    32'h00000005, 32'h00000000, 32'h00000005});
    vecs.push_back('{DIVU,   32'h00000005, 32'h00000000, 32'hffffffff});
    vecs.push_back('{REMU,   32'h00000005, 32'h00000000, 32'h00000005});
    vecs.push_back('{DIV,    32'h80000000, 32'hffffffff, 32'h80000000});
    vecs.push_back('{REM,    32'h80000000, 32'hffffffff, 32'h00000000});
    vecs.push_back('{DIVU,   32'h80000000, 32'hffffffff, 32'h00000000});
    vecs.push_back('{DIVU,   32'hfffffffe, 32'hffffffff, 32'h00000000});
    vecs.push_back('{REMU,   32'hfffffffe, 32'hffffffff, 32'hfffffffe});

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d_%s", i, vecs[i].op.name()));

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h80000000;
        rb = 32'hffffffff;
      end
      run_op(rop, ra, rb, ref_mdu(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
    end

    // backpressure in DONE
    issue(3'(DIVU), 32'd100, 32'd7);
    wait_rsp(60, 37, cyc, bad);
    chk("bp latency", 32'(cyc), 32'd37);
    chk("bp rd", rsp_rd, 32'd14);
    held = rsp_rd;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_rd !== held || req_rdy !== 1'b0 || rsp_vld !== 1'b1 || alu_own !== 1'b0) bad++;
    end
    chk("bp hold stable", 32'(bad), 32'd0);
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
    chk("bp release req_rdy", 32'(req_rdy), 32'd1);
    run_op(3'(MUL), 32'd6, 32'd7, 32'd42, "after bp");

    // kill in the tenth LOOP cycle (cycle 12)
    issue(3'(MUL), 32'd12345, 32'd678);
    repeat (12) @(negedge clk);
    chk("kill pre alu_own", 32'(alu_own), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill to idle", 32'({req_rdy, rsp_vld, alu_own}), 32'b100);
    hits = 0;
    repeat (45) begin
      @(negedge clk);
      if (rsp_vld === 1'b1 || alu_own === 1'b1) hits++;
    end
    chk("kill no rsp", 32'(hits), 32'd0);

    // kill in IDLE blocks acceptance
    @(negedge clk);
    req_vld = 1'b1;
    req_op  = 3'(MUL);
    req_rs1 = 32'd3;
    req_rs2 = 32'd3;
    kill    = 1'b1;
    @(posedge clk);
    #1;
    kill    = 1'b0;
    req_vld = 1'b0;
    chk("kill idle blocks", 32'({req_rdy, alu_own}), 32'b10);
    @(negedge clk);
    chk("kill idle stays", 32'({req_rdy, alu_own, rsp_vld}), 32'b100);

    // asynchronous reset in LOOP
    issue(3'(DIV), 32'd1000, 32'hfffffffd);
    repeat (20) @(negedge clk);
    chk("pre reset alu_own", 32'(alu_own), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b1;
    run_op(3'(DIV), 32'd1000, 32'hfffffffd, 32'hfffffeb3, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
